// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular arithmetic blocks: the exponentiation
// FSM state encoding, multiplier timing constants and a latency helper.
package mod_arith_pkg;

    localparam int DEFAULT_WIDTH = 1024;

    // One serial multiply: start cycle + one cycle per operand bit + capture cycle.
    localparam int MUL_CYCLES = DEFAULT_WIDTH + 2;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RED_START = 4'd1,
        RED_WAIT  = 4'd2,
        SQ_START  = 4'd3,
        SQ_WAIT   = 4'd4,
        MUL_START = 4'd5,
        MUL_WAIT  = 4'd6,
        NEXT_BIT  = 4'd7,
        DONE      = 4'd8
    } state_t;

    // Multiplier occupancy for an arbitrary operand width.
    function automatic int mul_cycles(input int w);
        return w + 2;
    endfunction

    // Cycles from the accept edge to dout_valid on the normal path (mod >= 2):
    // one reduction, w squarings, one multiply per set exponent bit, plus the
    // cycle that registers the result in DONE.
    function automatic int exp_latency(input int w, input int exp_popcount);
        return (1 + w + exp_popcount) * (w + 2) + 1;
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: res = a * b mod m, with b < m.
// Scans a from MSB to LSB, doubling the partial product and adding b, then
// folding back below m with at most two subtractions.
module mod_mul_serial #(
    parameter int W = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic         done,
    output logic [W-1:0] res
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  m_r;
    logic [W-1:0]  p_r;
    logic [CW-1:0] cnt;
    logic          busy;

    logic [W+1:0]  m_ext;
    logic [W+1:0]  t0;
    logic [W+1:0]  t1;
    logic [W+1:0]  t2;
    logic [1:0]    unused_top;

    // One iteration: 2P + a_i*B stays below 3M, so two conditional
    // subtractions always bring it back into [0, M).
    always_comb begin
        m_ext = {2'b00, m_r};
        t0    = {1'b0, p_r, 1'b0} + (a_r[W-1] ? {2'b00, b_r} : '0);
        t1    = (t0 >= m_ext) ? (t0 - m_ext) : t0;
        t2    = (t1 >= m_ext) ? (t1 - m_ext) : t1;
    end

    // After reduction the top two bits are always zero.
    assign unused_top = t2[W+1:W];

    // Operand capture on start, W iterations, then a one-cycle done pulse
    // with the result held in res.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r  <= '0;
            b_r  <= '0;
            m_r  <= '0;
            p_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            res  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r  <= a;
                b_r  <= b;
                m_r  <= m;
                p_r  <= '0;
                cnt  <= CW'(W);
                busy <= 1'b1;
            end else if (busy) begin
                p_r <= t2[W-1:0];
                a_r <= a_r << 1;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    res  <= t2[W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/mod_exp.sv
// Modular exponentiation engine: res = base^exp mod mod, left-to-right
// square-and-multiply over mod_mul_serial. Every exponent bit is processed
// (no leading-zero skip) so latency depends only on W and popcount(exp).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. din_ready is high only in IDLE. dout_valid and dout_bits_res
// stay stable until the edge where dout_ready is seen high; the block then
// returns to IDLE on the following cycle, so input and output transfers never
// share an edge.
module mod_exp
    import mod_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_bits_base,
    input  logic [DATA_WIDTH-1:0] din_bits_exp,
    input  logic [DATA_WIDTH-1:0] din_bits_mod,
    input  logic                  dout_ready,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout_bits_res
);

    localparam int W  = DATA_WIDTH;
    localparam int IW = $clog2(W);

    state_t        state;
    logic [W-1:0]  base_r;
    logic [W-1:0]  exp_r;
    logic [W-1:0]  mod_r;
    logic [W-1:0]  x_r;
    logic [W-1:0]  r_r;
    logic [IW-1:0] bit_idx;

    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_done;
    logic [W-1:0]  mul_res;

    assign din_ready = (state == IDLE);

    // Multiplier launch and operand selection decoded from the START states.
    always_comb begin
        mul_start = 1'b0;
        mul_a     = r_r;
        mul_b     = r_r;
        case (state)
            RED_START: begin
                mul_start = 1'b1;
                mul_a     = base_r;
                mul_b     = W'(1);
            end
            SQ_START: begin
                mul_start = 1'b1;
            end
            MUL_START: begin
                mul_start = 1'b1;
                mul_b     = x_r;
            end
            default: begin
            end
        endcase
    end

    mod_mul_serial #(.W(W)) u_mul (
        .clock (clock),
        .reset (reset),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .m     (mod_r),
        .done  (mul_done),
        .res   (mul_res)
    );

    // Control FSM. exp_r is shifted left as bits are consumed so the current
    // bit is always exp_r[W-1]; bit_idx counts the remaining bits. The
    // bit-advance step is folded into the capture edge of the last multiply
    // for that bit, so NEXT_BIT is never occupied for a cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            base_r        <= '0;
            exp_r         <= '0;
            mod_r         <= '0;
            x_r           <= '0;
            r_r           <= '0;
            bit_idx       <= '0;
            dout_valid    <= 1'b0;
            dout_bits_res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        base_r <= din_bits_base;
                        exp_r  <= din_bits_exp;
                        mod_r  <= din_bits_mod;
                        if (din_bits_mod < W'(2)) begin
                            r_r   <= '0;
                            state <= DONE;
                        end else begin
                            state <= RED_START;
                        end
                    end
                end
                RED_START: state <= RED_WAIT;
                RED_WAIT: begin
                    if (mul_done) begin
                        x_r     <= mul_res;
                        r_r     <= W'(1);
                        bit_idx <= IW'(W - 1);
                        state   <= SQ_START;
                    end
                end
                SQ_START: state <= SQ_WAIT;
                SQ_WAIT: begin
                    if (mul_done) begin
                        r_r <= mul_res;
                        if (exp_r[W-1]) begin
                            state <= MUL_START;
                        end else if (bit_idx == '0) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                            exp_r   <= exp_r << 1;
                            state   <= SQ_START;
                        end
                    end
                end
                MUL_START: state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (mul_done) begin
                        r_r <= mul_res;
                        if (bit_idx == '0) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                            exp_r   <= exp_r << 1;
                            state   <= SQ_START;
                        end
                    end
                end
                NEXT_BIT: begin
                    if (bit_idx == '0) begin
                        state <= DONE;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                        exp_r   <= exp_r << 1;
                        state   <= SQ_START;
                    end
                end
                DONE: begin
                    if (!dout_valid) begin
                        dout_valid    <= 1'b1;
                        dout_bits_res <= r_r;
                    end else if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp.sv
// Directed bench for mod_exp: a W=16 instance for the arithmetic, latency,
// backpressure and reset cases, and a W=1024 instance for reset state and
// the mod<2 short path.
`timescale 1ns/1ps
module tb_mod_exp;
    import mod_arith_pkg::*;

    localparam int W = 16;
    localparam int K = 1024;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // W=16 instance
    logic         din_valid16 = 1'b0;
    logic         din_ready16;
    logic [W-1:0] base16 = '0;
    logic [W-1:0] expo16 = '0;
    logic [W-1:0] mod16 = '0;
    logic         dout_ready16 = 1'b0;
    logic         dout_valid16;
    logic [W-1:0] res16;

    mod_exp #(.DATA_WIDTH(W)) dut16 (
        .clock         (clock),
        .reset         (reset),
        .din_valid     (din_valid16),
        .din_ready     (din_ready16),
        .din_bits_base (base16),
        .din_bits_exp  (expo16),
        .din_bits_mod  (mod16),
        .dout_ready    (dout_ready16),
        .dout_valid    (dout_valid16),
        .dout_bits_res (res16)
    );

    // W=1024 instance
    logic         din_valid1k = 1'b0;
    logic         din_ready1k;
    logic [K-1:0] base1k = '0;
    logic [K-1:0] expo1k = '0;
    logic [K-1:0] mod1k = '0;
    logic         dout_ready1k = 1'b0;
    logic         dout_valid1k;
    logic [K-1:0] res1k;

    mod_exp #(.DATA_WIDTH(K)) dut1k (
        .clock         (clock),
        .reset         (reset),
        .din_valid     (din_valid1k),
        .din_ready     (din_ready1k),
        .din_bits_base (base1k),
        .din_bits_exp  (expo1k),
        .din_bits_mod  (mod1k),
        .dout_ready    (dout_ready1k),
        .dout_valid    (dout_valid1k),
        .dout_bits_res (res1k)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    typedef struct {
        logic [W-1:0] base;
        logic [W-1:0] expo;
        logic [W-1:0] modv;
        logic [W-1:0] res;
        int           lat;
        int           bp;     // cycles to hold dout_ready low after dout_valid
        bit           early;  // dout_ready already high during computation
    } vec_t;

    vec_t vecs[12];

    localparam int WAIT_BUDGET = 2000;

    // ---------------- driver tasks ----------------
    task automatic wait_idle16();
        int n = 0;
        while (!din_ready16 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check("idle_ready16", din_ready16, 1);
    endtask

    task automatic run16(input vec_t v, input int idx);
        int   cnt;
        bit   rdy_bad;
        int   bad;
        logic [W-1:0] held;
        logic [W-1:0] e;
        wait_idle16();
        base16       = v.base;
        expo16       = v.expo;
        mod16        = v.modv;
        din_valid16  = 1'b1;
        dout_ready16 = v.early;
        @(posedge clock); #1;
        din_valid16 = 1'b0;
        base16 = W'($urandom_range(0, 65535));
        expo16 = W'($urandom_range(0, 65535));
        mod16  = W'($urandom_range(0, 65535));
        exp_q.push_back(v.res);
        cnt = 0;
        rdy_bad = 1'b0;
        while (!dout_valid16 && cnt < WAIT_BUDGET) begin
            @(posedge clock); #1; cnt++;
            if (din_ready16) rdy_bad = 1'b1;
        end
        check($sformatf("v%0d_latency", idx), cnt, v.lat);
        check($sformatf("v%0d_ready_low", idx), rdy_bad, 0);
        e = exp_q.pop_front();
        check($sformatf("v%0d_res", idx), res16, e);
        if (!v.early) begin
            held = res16;
            bad  = 0;
            repeat (v.bp) begin
                @(posedge clock); #1;
                if (res16 !== held || dout_valid16 !== 1'b1 || din_ready16 !== 1'b0) bad++;
            end
            if (v.bp > 0) check($sformatf("v%0d_backpressure", idx), bad, 0);
            dout_ready16 = 1'b1;
        end
        @(posedge clock); #1;
        check($sformatf("v%0d_release_valid", idx), dout_valid16, 0);
        check($sformatf("v%0d_release_ready", idx), din_ready16, 1);
        dout_ready16 = 1'b0;
    endtask

    task automatic run1k_short(input logic [K-1:0] m, input string name);
        int cnt;
        for (int i = 0; i < K / 32; i++) begin
            base1k[i*32 +: 32] = $urandom;
            expo1k[i*32 +: 32] = $urandom;
        end
        mod1k       = m;
        din_valid1k = 1'b1;
        @(posedge clock); #1;
        din_valid1k = 1'b0;
        mod1k = '1;
        cnt = 0;
        while (!dout_valid1k && cnt < 50) begin
            @(posedge clock); #1; cnt++;
        end
        check({name, "_latency"}, cnt, 1);
        check({name, "_res_lo"}, res1k[63:0], 0);
        check({name, "_res_hi_nz"}, {63'd0, |res1k[K-1:64]}, 0);
        dout_ready1k = 1'b1;
        @(posedge clock); #1;
        dout_ready1k = 1'b0;
        check({name, "_release_ready"}, din_ready1k, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   cnt;
        bit   seen;
        vecs[0]  = '{16'd4,     16'd13,    16'd497,   16'd445,   361, 5, 1'b0};
        vecs[1]  = '{16'd1000,  16'd1,     16'd497,   16'd6,     325, 0, 1'b0};
        vecs[2]  = '{16'd65,    16'd17,    16'd3233,  16'd2790,  343, 0, 1'b0};
        vecs[3]  = '{16'd2790,  16'd2753,  16'd3233,  16'd65,    397, 0, 1'b0};
        vecs[4]  = '{16'd5,     16'd0,     16'd497,   16'd1,     307, 0, 1'b0};
        vecs[5]  = '{16'd7,     16'd3,     16'd1,     16'd0,     1,   2, 1'b0};
        vecs[6]  = '{16'd9,     16'd5,     16'd0,     16'd0,     1,   0, 1'b0};
        vecs[7]  = '{16'd65534, 16'd1,     16'd65535, 16'd65534, 325, 0, 1'b1};
        vecs[8]  = '{16'd2,     16'd16,    16'd65535, 16'd1,     325, 0, 1'b0};
        vecs[9]  = '{16'd65535, 16'd2,     16'd65521, 16'd196,   325, 0, 1'b0};
        vecs[10] = '{16'd3,     16'd5,     16'd2,     16'd1,     343, 0, 1'b0};
        vecs[11] = '{16'd0,     16'd5,     16'd497,   16'd0,     343, 0, 1'b0};

        // reset state, sampled while reset is still asserted
        repeat (3) @(posedge clock);
        #1;
        check("rst_din_ready16", din_ready16, 1);
        check("rst_dout_valid16", dout_valid16, 0);
        check("rst_res16", res16, 0);
        check("rst_din_ready1k", din_ready1k, 1);
        check("rst_dout_valid1k", dout_valid1k, 0);
        check("rst_res1k_nz", {63'd0, |res1k}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 12; i++) run16(vecs[i], i);

        run1k_short('0, "k_mod0");
        run1k_short(K'(1), "k_mod1");

        // reset 100 cycles into the base case: abort with no result
        wait_idle16();
        base16 = 16'd4; expo16 = 16'd13; mod16 = 16'd497;
        din_valid16 = 1'b1;
        @(posedge clock); #1;
        din_valid16 = 1'b0;
        repeat (100) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("midrst_dout_valid", dout_valid16, 0);
        check("midrst_din_ready", din_ready16, 1);
        check("midrst_res", res16, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 1'b0;
        cnt = 0;
        while (cnt < exp_latency(W, 16) + 20) begin
            @(posedge clock); #1; cnt++;
            if (dout_valid16) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);
        run16(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
